// File: rtl/rvv_vd_collector.sv
// Write-back collector: assembles lane result chunks into a VLEN-wide destination
// image and issues a single byte-enabled write-back once all bytes below vl are present.
module rvv_vd_collector #(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned LANE_WIDTH = 3,
   parameter int unsigned VLENB_W    = $clog2(VLEN/8) + 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [VLENB_W-1:0] vl_bytes,
   input  logic [4:0]         vd_addr_in,
   input  logic               abort,
   input  logic               chunk_valid,
   output logic               chunk_ready,
   input  logic [63:0]        chunk_data,
   input  logic [9:0]         chunk_index,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [4:0]         wb_addr,
   output logic [VLEN-1:0]    wb_data,
   output logic [VLEN/8-1:0]  wb_be,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int unsigned VLENB       = VLEN / 8;
   localparam int unsigned CHUNK_BYTES = 1 << (LANE_WIDTH - 3);
   localparam int unsigned BIDX_W      = (VLENB_W > 8) ? VLENB_W : 8;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [VLENB_W-1:0] vl_q, vl_d;
   logic [4:0]         addr_q, addr_d;
   logic [VLEN-1:0]    buf_q, buf_d;
   logic [VLENB-1:0]   mask_q, mask_d;
   logic [VLENB-1:0]   need;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               chunk_ready_q;
   logic               wb_valid_q;
   logic               busy_q;
   logic [BIDX_W-1:0]  idx;

   // Low index bits and unused upper data lanes are architecturally ignored.
   logic unused_bits;
   assign unused_bits = ^{chunk_index[2:0], chunk_data};

   // Bytes that must be present before the image is complete.
   always_comb begin
      need = '0;
      for (int i = 0; i < int'(VLENB); i++) begin
         need[i] = (VLENB_W'(i) < vl_q);
      end
   end

   // Next-state, datapath and registered-output next values.
   always_comb begin
      state_d = state_q;
      vl_d    = vl_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      mask_d  = mask_q;
      err_d   = err_q;
      done_d  = 1'b0;
      idx     = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d = 1'b0;
               if (vl_bytes != '0) begin
                  vl_d    = vl_bytes;
                  addr_d  = vd_addr_in;
                  buf_d   = '0;
                  mask_d  = '0;
                  state_d = S_COLLECT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (abort) begin
               mask_d  = '0;
               state_d = S_IDLE;
            end else if (chunk_valid) begin
               for (int k = 0; k < int'(CHUNK_BYTES); k++) begin
                  idx = BIDX_W'(chunk_index[9:3]) + BIDX_W'(k);
                  if (idx < BIDX_W'(vl_q)) begin
                     for (int j = 0; j < int'(VLENB); j++) begin
                        if (idx == BIDX_W'(j)) begin
                           buf_d[j*8 +: 8] = chunk_data[k*8 +: 8];
                           mask_d[j]       = 1'b1;
                        end
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end
               if ((mask_d & need) == need) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (abort) begin
               mask_d  = '0;
               state_d = S_IDLE;
            end else if (wb_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         vl_q          <= '0;
         addr_q        <= '0;
         buf_q         <= '0;
         mask_q        <= '0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         chunk_ready_q <= 1'b0;
         wb_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         vl_q          <= vl_d;
         addr_q        <= addr_d;
         buf_q         <= buf_d;
         mask_q        <= mask_d;
         err_q         <= err_d;
         done_q        <= done_d;
         chunk_ready_q <= (state_d == S_COLLECT);
         wb_valid_q    <= (state_d == S_WRITE);
         busy_q        <= (state_d != S_IDLE);
      end
   end

   assign chunk_ready = chunk_ready_q;
   assign wb_valid    = wb_valid_q;
   assign wb_addr     = addr_q;
   assign wb_data     = buf_q;
   assign wb_be       = mask_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Bench for rvv_vd_collector: cycle table, directed sequences and randomized
// transactions checked against a byte-array model of the destination image.
module tb_rvv_vd_collector;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [4:0]    vl_bytes;
   logic [4:0]    vd_addr_in;
   logic          abort;
   logic          chunk_valid;
   logic          chunk_ready;
   logic [63:0]   chunk_data;
   logic [9:0]    chunk_index;
   logic          wb_valid;
   logic          wb_ready;
   logic [4:0]    wb_addr;
   logic [127:0]  wb_data;
   logic [15:0]   wb_be;
   logic          busy;
   logic          done;
   logic          err;

   rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(3)) dut (
      .clk(clk), .resetn(resetn), .start(start), .vl_bytes(vl_bytes),
      .vd_addr_in(vd_addr_in), .abort(abort), .chunk_valid(chunk_valid),
      .chunk_ready(chunk_ready), .chunk_data(chunk_data), .chunk_index(chunk_index),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_be(wb_be), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic         start;
      logic [4:0]   vl;
      logic [4:0]   addr;
      logic         cv;
      logic [9:0]   idx;
      logic [7:0]   dat;
      logic         wr;
      logic         ab;
      logic         e_rdy;
      logic         e_wbv;
      logic         e_busy;
      logic         e_done;
      logic         e_err;
      logic         d_chk;
      logic [15:0]  e_be;
      logic [4:0]   e_addr;
      logic [127:0] e_data;
   } vec_t;

   // Model of the destination image.
   logic [7:0] mbuf [16];
   logic       mset [16];
   logic       merr;
   logic [9:0] tx_idx [$];
   logic [7:0] tx_dat [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; vl_bytes = 0; vd_addr_in = 0; abort = 0;
      chunk_valid = 0; chunk_data = 0; chunk_index = 0; wb_ready = 0;
   endtask

   task automatic run_txn(input int vl, input logic [4:0] addr, input int hold);
      logic         cmpl;
      logic [127:0] edata;
      logic [15:0]  ebe;
      int           b;
      start = 1; vl_bytes = 5'(vl); vd_addr_in = addr;
      cyc();
      start = 0;
      for (int i = 0; i < 16; i++) begin mbuf[i] = 8'h0; mset[i] = 1'b0; end
      merr = 1'b0;
      chk("start_busy", 128'(busy), 128'(1));
      chk("start_chunk_ready", 128'(chunk_ready), 128'(1));
      chk("start_err_clear", 128'(err), 128'(0));
      cmpl = 1'b0;
      for (int n = 0; n < tx_idx.size() && !cmpl; n++) begin
         chunk_valid = 1; chunk_index = tx_idx[n]; chunk_data = 64'(tx_dat[n]);
         cyc();
         b = int'(tx_idx[n] >> 3);
         if (b < vl) begin mbuf[b] = tx_dat[n]; mset[b] = 1'b1; end
         else merr = 1'b1;
         cmpl = 1'b1;
         for (int i = 0; i < vl; i++) if (!mset[i]) cmpl = 1'b0;
         chk("wb_valid_timing", 128'(wb_valid), 128'(cmpl));
         chk("err_sticky", 128'(err), 128'(merr));
      end
      for (int i = 0; i < 16; i++) begin edata[i*8 +: 8] = mbuf[i]; ebe[i] = mset[i]; end
      // Junk chunks during back-pressure must be ignored.
      chunk_valid = 1; chunk_index = 10'h0; chunk_data = 64'hEE;
      wb_ready = 0;
      for (int h = 0; h < hold; h++) begin
         cyc();
         chk("hold_wb_valid", 128'(wb_valid), 128'(1));
         chk("hold_chunk_ready", 128'(chunk_ready), 128'(0));
         chk("hold_wb_data", wb_data, edata);
         chk("hold_wb_be", 128'(wb_be), 128'(ebe));
      end
      chunk_valid = 0;
      chk("wb_data", wb_data, edata);
      chk("wb_be", 128'(wb_be), 128'(ebe));
      chk("wb_addr", 128'(wb_addr), 128'(addr));
      chk("write_done_low", 128'(done), 128'(0));
      wb_ready = 1;
      cyc();
      wb_ready = 0;
      chk("release_wb_valid", 128'(wb_valid), 128'(0));
      chk("release_done", 128'(done), 128'(1));
      chk("release_busy", 128'(busy), 128'(0));
      cyc();
      chk("done_one_cycle", 128'(done), 128'(0));
   endtask

   task automatic gen_random(input int vl);
      logic cov [16];
      logic all;
      int   byt;
      tx_idx.delete(); tx_dat.delete();
      for (int i = 0; i < 16; i++) cov[i] = 1'b0;
      all = 1'b0;
      while (!all) begin
         if ($urandom_range(0, 7) == 0) byt = int'($urandom_range(vl, 127));
         else byt = int'($urandom_range(0, vl - 1));
         tx_idx.push_back(10'(byt * 8 + int'($urandom_range(0, 7))));
         tx_dat.push_back(8'($urandom));
         if (byt < vl) cov[byt] = 1'b1;
         all = 1'b1;
         for (int i = 0; i < vl; i++) if (!cov[i]) all = 1'b0;
      end
   endtask

   initial begin
      vec_t tbl [9];
      tbl[0] = '{1, 3, 7, 0, 0,   8'h00, 0, 0,  1, 0, 1, 0, 0,  0, 16'h0, 5'd0, 128'h0};
      tbl[1] = '{0, 0, 0, 1, 40,  8'h55, 0, 0,  1, 0, 1, 0, 1,  0, 16'h0, 5'd0, 128'h0};
      tbl[2] = '{0, 0, 0, 1, 0,   8'hA0, 0, 0,  1, 0, 1, 0, 1,  0, 16'h0, 5'd0, 128'h0};
      tbl[3] = '{0, 0, 0, 1, 8,   8'hA1, 0, 0,  1, 0, 1, 0, 1,  0, 16'h0, 5'd0, 128'h0};
      tbl[4] = '{0, 0, 0, 1, 16,  8'hA2, 0, 0,  0, 1, 1, 0, 1,  1, 16'h0007, 5'd7, 128'hA2A1A0};
      tbl[5] = '{0, 0, 0, 0, 0,   8'h00, 1, 0,  0, 0, 0, 1, 1,  0, 16'h0, 5'd0, 128'h0};
      tbl[6] = '{0, 0, 0, 0, 0,   8'h00, 0, 1,  0, 0, 0, 0, 1,  0, 16'h0, 5'd0, 128'h0};
      tbl[7] = '{1, 0, 0, 0, 0,   8'h00, 0, 0,  0, 0, 0, 1, 0,  0, 16'h0, 5'd0, 128'h0};
      tbl[8] = '{0, 0, 0, 0, 0,   8'h00, 0, 0,  0, 0, 0, 0, 0,  0, 16'h0, 5'd0, 128'h0};

      idle_inputs();
      resetn = 0;
      cyc(); cyc();
      resetn = 1;
      chk("rst_chunk_ready", 128'(chunk_ready), 128'(0));
      chk("rst_wb_valid", 128'(wb_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_wb_addr", 128'(wb_addr), 128'(0));
      chk("rst_wb_data", wb_data, 128'h0);
      chk("rst_wb_be", 128'(wb_be), 128'(0));

      // Partial vl with an out-of-range chunk, idle abort, zero-length start.
      for (int v = 0; v < 9; v++) begin
         start = tbl[v].start; vl_bytes = tbl[v].vl; vd_addr_in = tbl[v].addr;
         chunk_valid = tbl[v].cv; chunk_index = tbl[v].idx; chunk_data = 64'(tbl[v].dat);
         wb_ready = tbl[v].wr; abort = tbl[v].ab;
         cyc();
         idle_inputs();
         chk($sformatf("tbl%0d_chunk_ready", v), 128'(chunk_ready), 128'(tbl[v].e_rdy));
         chk($sformatf("tbl%0d_wb_valid", v), 128'(wb_valid), 128'(tbl[v].e_wbv));
         chk($sformatf("tbl%0d_busy", v), 128'(busy), 128'(tbl[v].e_busy));
         chk($sformatf("tbl%0d_done", v), 128'(done), 128'(tbl[v].e_done));
         chk($sformatf("tbl%0d_err", v), 128'(err), 128'(tbl[v].e_err));
         if (tbl[v].d_chk) begin
            chk($sformatf("tbl%0d_wb_be", v), 128'(wb_be), 128'(tbl[v].e_be));
            chk($sformatf("tbl%0d_wb_addr", v), 128'(wb_addr), 128'(tbl[v].e_addr));
            chk($sformatf("tbl%0d_wb_data", v), wb_data, tbl[v].e_data);
         end
      end

      // Full in-order assembly.
      tx_idx.delete(); tx_dat.delete();
      for (int i = 0; i < 16; i++) begin tx_idx.push_back(10'(i * 8)); tx_dat.push_back(8'(8'h10 + i)); end
      run_txn(16, 5'd5, 0);

      // Out-of-order with a duplicate: completes on the fifth chunk.
      tx_idx.delete(); tx_dat.delete();
      tx_idx = '{10'd24, 10'd0, 10'd16, 10'd0, 10'd8};
      tx_dat = '{8'h33, 8'h30, 8'h32, 8'hAA, 8'h31};
      run_txn(4, 5'd9, 0);

      // Back-pressure for five cycles.
      tx_idx.delete(); tx_dat.delete();
      tx_idx = '{10'd8, 10'd0};
      tx_dat = '{8'h5A, 8'hC3};
      run_txn(2, 5'd30, 5);

      // Abort mid-collection, then a start that must not inherit the old mask.
      start = 1; vl_bytes = 5'd16; vd_addr_in = 5'd3;
      cyc();
      start = 0;
      chunk_valid = 1; chunk_index = 10'd0; chunk_data = 64'h77; cyc();
      chunk_index = 10'd8; chunk_data = 64'h78; cyc();
      chunk_valid = 0; abort = 1;
      cyc();
      abort = 0;
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_wb_valid", 128'(wb_valid), 128'(0));
      chk("abort_chunk_ready", 128'(chunk_ready), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      cyc();
      chk("abort_done_later", 128'(done), 128'(0));
      tx_idx.delete(); tx_dat.delete();
      for (int i = 2; i < 16; i++) begin tx_idx.push_back(10'(i * 8)); tx_dat.push_back(8'(8'h40 + i)); end
      tx_idx.push_back(10'd0); tx_dat.push_back(8'h40);
      tx_idx.push_back(10'd8); tx_dat.push_back(8'h41);
      run_txn(16, 5'd4, 1);

      // Reset while a write-back is pending.
      start = 1; vl_bytes = 5'd1; vd_addr_in = 5'd12;
      cyc();
      start = 0;
      chunk_valid = 1; chunk_index = 10'd400; chunk_data = 64'h11; cyc();
      chunk_index = 10'd0; chunk_data = 64'h22; cyc();
      chunk_valid = 0;
      chk("pre_reset_wb_valid", 128'(wb_valid), 128'(1));
      chk("pre_reset_err", 128'(err), 128'(1));
      resetn = 0;
      cyc();
      resetn = 1;
      chk("midrst_wb_valid", 128'(wb_valid), 128'(0));
      chk("midrst_busy", 128'(busy), 128'(0));
      chk("midrst_wb_be", 128'(wb_be), 128'(0));
      chk("midrst_err", 128'(err), 128'(0));
      chk("midrst_done", 128'(done), 128'(0));
      tx_idx.delete(); tx_dat.delete();
      tx_idx = '{10'd0};
      tx_dat = '{8'h99};
      run_txn(1, 5'd12, 0);

      // Randomized transactions.
      for (int t = 0; t < 30; t++) begin
         int vl;
         vl = int'($urandom_range(1, 16));
         gen_random(vl);
         run_txn(vl, 5'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
